// File: rtl/decode_stage_pkg.sv
// Shared types for the RV32 decode stage: opcodes, ALU functions, the control
// word and the decoded_t record stored in the stage's main and skid entries.
package decode_stage_pkg;

  localparam int DEC_XLEN = 32;

  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_FUNC_ADD, ALU_FUNC_SUB, ALU_FUNC_SLL, ALU_FUNC_SLT, ALU_FUNC_SLTU,
    ALU_FUNC_XOR, ALU_FUNC_SRL, ALU_FUNC_SRA, ALU_FUNC_OR, ALU_FUNC_AND,
    ALU_FUNC_SEQ, ALU_FUNC_UNKNOWN
  } alu_func_e;

  typedef struct packed {
    logic      use_imm;
    logic      rd_write;
    alu_func_e alu_func;
  } control_t;

  typedef struct packed {
    control_t              ctrl;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [DEC_XLEN-1:0]   imm;
    logic                  is_branch;
    logic [2:0]            br_funct3;
    logic [DEC_XLEN-1:0]   pc;
    logic                  illegal;
  } decoded_t;

  // Base-encoding ALU function for a funct3 (shift-right defaults to logical).
  function automatic alu_func_e f3_base_func(logic [2:0] f3);
    case (f3)
      F3_ADD:  return ALU_FUNC_ADD;
      F3_SLL:  return ALU_FUNC_SLL;
      F3_SLT:  return ALU_FUNC_SLT;
      F3_SLTU: return ALU_FUNC_SLTU;
      F3_XOR:  return ALU_FUNC_XOR;
      F3_SR:   return ALU_FUNC_SRL;
      F3_OR:   return ALU_FUNC_OR;
      default: return ALU_FUNC_AND;
    endcase
  endfunction

  function automatic decoded_t decoded_rst();
    decoded_t d;
    d = '0;
    d.ctrl.alu_func = ALU_FUNC_UNKNOWN;
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// Combinational RV32 decoder: raw instruction + PC to a decoded_t record.
module instr_decoder
  import decode_stage_pkg::*;
(
  input  logic [31:0]         instr_i,
  input  logic [DEC_XLEN-1:0] pc_i,
  output decoded_t            dec_o
);

  logic [6:0]          opc, f7;
  logic [2:0]          f3;
  logic [DEC_XLEN-1:0] i_imm, b_imm, imm;
  logic                ill, use_imm, rd_wr, is_br;
  alu_func_e           func;

  always_comb begin
    opc   = instr_i[6:0];
    f3    = instr_i[14:12];
    f7    = instr_i[31:25];
    i_imm = {{(DEC_XLEN-12){instr_i[31]}}, instr_i[31:20]};
    b_imm = {{(DEC_XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7],
             instr_i[30:25], instr_i[11:8], 1'b0};
    ill     = 1'b1;
    func    = ALU_FUNC_UNKNOWN;
    use_imm = 1'b0;
    rd_wr   = 1'b0;
    imm     = '0;
    is_br   = 1'b0;
    case (opc)
      OPCODE_OP_IMM: begin
        // funct7 only constrains the shift forms; elsewhere it is immediate bits
        ill = (f3 == F3_SLL && f7 != FUNCT7_BASE) ||
              (f3 == F3_SR && f7 != FUNCT7_BASE && f7 != FUNCT7_ALT);
        func    = (f3 == F3_SR && f7 == FUNCT7_ALT) ? ALU_FUNC_SRA : f3_base_func(f3);
        use_imm = 1'b1;
        rd_wr   = 1'b1;
        imm     = i_imm;
      end
      OPCODE_OP: begin
        ill   = !(f7 == FUNCT7_BASE || (f7 == FUNCT7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
        func  = (f7 == FUNCT7_ALT) ? ((f3 == F3_ADD) ? ALU_FUNC_SUB : ALU_FUNC_SRA)
                                   : f3_base_func(f3);
        rd_wr = 1'b1;
      end
      OPCODE_BRANCH: begin
        is_br = 1'b1;
        ill   = (f3 == 3'b010) || (f3 == 3'b011);
        func  = !f3[2] ? ALU_FUNC_SEQ : (f3[1] ? ALU_FUNC_SLTU : ALU_FUNC_SLT);
        imm   = b_imm;
      end
      default: ;
    endcase

    dec_o               = '0;
    dec_o.ctrl.use_imm  = use_imm & ~ill;
    dec_o.ctrl.rd_write = rd_wr & ~ill;
    dec_o.ctrl.alu_func = ill ? ALU_FUNC_UNKNOWN : func;
    dec_o.imm           = ill ? '0 : imm;
    dec_o.rs1           = instr_i[19:15];
    dec_o.rs2           = instr_i[24:20];
    dec_o.rd            = instr_i[11:7];
    dec_o.is_branch     = is_br;
    dec_o.br_funct3     = is_br ? f3 : 3'b000;
    dec_o.pc            = pc_i;
    dec_o.illegal       = ill;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: output register plus one skid entry, valid/ready on
// both sides. Define DECODE_PERF_CNT_EN to add saturating beat counters.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN           = DEC_XLEN,
  parameter int RESET_PC_VALID = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output control_t        out_ctrl,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_is_branch,
  output logic [2:0]      out_br_funct3,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]     perf_decoded,
  output logic [15:0]     perf_illegal
`endif
);

  decoded_t dec, main_q, main_d, skid_q, skid_d;
  logic     main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, accept;

  instr_decoder u_dec (.instr_i(in_instr), .pc_i(in_pc), .dec_o(dec));

  assign in_ready = ~skid_vld_q;
  assign accept   = in_valid & ~skid_vld_q;

  // skid is only ever valid while main is valid, so draining main promotes it
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || out_ready) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = dec;
      end
    end else if (accept) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= decoded_rst();
      skid_q     <= decoded_rst();
      main_vld_q <= (RESET_PC_VALID != 0);  // reserved; must be 0
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_valid     = main_vld_q;
  assign out_ctrl      = main_q.ctrl;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_rd        = main_q.rd;
  assign out_imm       = main_q.imm;
  assign out_is_branch = main_q.is_branch;
  assign out_br_funct3 = main_q.br_funct3;
  assign out_pc        = main_q.pc;
  assign out_illegal   = main_q.illegal;

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] perf_decoded_q;
  logic [15:0] perf_illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_decoded_q <= '0;
      perf_illegal_q <= '0;
    end else if (main_vld_q && out_ready) begin
      if (~&perf_decoded_q) perf_decoded_q <= perf_decoded_q + 32'd1;
      if (main_q.illegal && ~&perf_illegal_q) perf_illegal_q <= perf_illegal_q + 16'd1;
    end
  end

  assign perf_decoded = perf_decoded_q;
  assign perf_illegal = perf_illegal_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Randomized scoreboard bench for decode_stage: driver pushes expected decodes
// from a spec-level model, a negedge monitor pops and compares each output beat.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic        in_ready, out_valid, out_is_branch, out_illegal;
  control_t    out_ctrl;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm, out_pc;
  logic [2:0]  out_br_funct3;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0] perf_decoded;
  logic [15:0] perf_illegal;
`endif

  decode_stage #(.XLEN(32), .RESET_PC_VALID(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_is_branch(out_is_branch), .out_br_funct3(out_br_funct3),
    .out_pc(out_pc), .out_illegal(out_illegal)
`ifdef DECODE_PERF_CNT_EN
    , .perf_decoded(perf_decoded), .perf_illegal(perf_illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    alu_func_e   alu;
    logic        use_imm, rd_write;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        is_br;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  int   errors = 0, checks = 0;
  exp_t sb[$];
  exp_t snap;
  logic stall_prev = 1'b0;
  int   tb_beats = 0, tb_ill = 0;

  // Reference decode straight from the ISA tables.
  function automatic exp_t model(logic [31:0] ins, logic [31:0] pc);
    alu_func_e  tbl[8];
    exp_t       e;
    int         f3, f7;
    bit         ok;
    logic [12:0] b;
    tbl = '{ALU_FUNC_ADD, ALU_FUNC_SLL, ALU_FUNC_SLT, ALU_FUNC_SLTU,
            ALU_FUNC_XOR, ALU_FUNC_SRL, ALU_FUNC_OR, ALU_FUNC_AND};
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    ok = 1'b0;
    e = '0;
    e.alu = ALU_FUNC_UNKNOWN;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.pc = pc;
    case (ins[6:0])
      7'h13: begin
        ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 32) : 1'b1;
        e.alu = (f3 == 5 && f7 == 32) ? ALU_FUNC_SRA : tbl[f3];
        e.use_imm = 1'b1; e.rd_write = 1'b1;
        e.imm = {{20{ins[31]}}, ins[31:20]};
      end
      7'h33: begin
        ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
        e.alu = (f7 == 32) ? ((f3 == 0) ? ALU_FUNC_SUB : ALU_FUNC_SRA) : tbl[f3];
        e.rd_write = 1'b1;
      end
      7'h63: begin
        e.is_br = 1'b1; e.f3 = ins[14:12];
        ok = (f3 != 2 && f3 != 3);
        e.alu = (f3 < 2) ? ALU_FUNC_SEQ : (f3 < 6) ? ALU_FUNC_SLT : ALU_FUNC_SLTU;
        b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        e.imm = {{19{b[12]}}, b};
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.alu = ALU_FUNC_UNKNOWN; e.use_imm = 1'b0; e.rd_write = 1'b0; e.imm = '0; e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t got();
    exp_t g;
    g.alu = out_ctrl.alu_func; g.use_imm = out_ctrl.use_imm; g.rd_write = out_ctrl.rd_write;
    g.rs1 = out_rs1; g.rs2 = out_rs2; g.rd = out_rd; g.imm = out_imm;
    g.is_br = out_is_branch; g.f3 = out_br_funct3; g.pc = out_pc; g.ill = out_illegal;
    return g;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_d(input string nm, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: pop on each output beat, push on each accepted input.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      stall_prev = 1'b0;
      tb_beats = 0;
      tb_ill = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat: got unexpected output pc %h want none", out_pc);
        end else begin
          chk_d("beat", got(), sb.pop_front());
          tb_beats++;
          if (out_illegal) tb_ill++;
        end
      end
      if (stall_prev && out_valid) chk_d("stall stable", got(), snap);
      stall_prev = out_valid && !out_ready && !flush;
      snap = got();
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(model(in_instr, in_pc));
    end
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl, output logic acc);
    @(posedge clk); #1;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy & ~fl; flush = fl;
    @(negedge clk);
    acc = v && in_ready && !fl;
  endtask

  // One instruction with out_ready high; returns at the negedge it is on the output.
  task automatic send1(input logic [31:0] ins, input logic [31:0] pc);
    logic a;
    step(1'b1, ins, pc, 1'b1, 1'b0, a);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op, f7;
    r = $urandom;
    case ($urandom_range(0, 7))
      0, 1, 2: op = 7'h13;
      3, 4:    op = 7'h33;
      5, 6:    op = 7'h63;
      default: op = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    r[6:0] = op;
    r[31:25] = f7;
    return r;
  endfunction

  logic [31:0] bp_ins[4];
  logic [31:0] cur, pcv, perf_snap;
  logic        a, saw_low;
  int          idx;

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst alu_func", 32'(out_ctrl.alu_func), 32'(ALU_FUNC_UNKNOWN));
    chk("rst imm", out_imm, 32'h0);
    chk("rst pc", out_pc, 32'h0);
    chk("rst illegal", 32'(out_illegal), 32'd0);

    // directed decodes
    send1(32'hFFF10093, 32'h100);
    chk("addi valid", 32'(out_valid), 32'd1);
    chk("addi alu", 32'(out_ctrl.alu_func), 32'(ALU_FUNC_ADD));
    chk("addi use_imm", 32'(out_ctrl.use_imm), 32'd1);
    chk("addi rd_write", 32'(out_ctrl.rd_write), 32'd1);
    chk("addi rs1", 32'(out_rs1), 32'd2);
    chk("addi rd", 32'(out_rd), 32'd1);
    chk("addi imm", out_imm, 32'hFFFFFFFF);
    chk("addi illegal", 32'(out_illegal), 32'd0);

    send1(32'h405201B3, 32'h104);
    chk("sub alu", 32'(out_ctrl.alu_func), 32'(ALU_FUNC_SUB));
    chk("sub use_imm", 32'(out_ctrl.use_imm), 32'd0);
    chk("sub regs", {17'h0, out_rs1, out_rs2, out_rd}, {17'h0, 5'd4, 5'd5, 5'd3});
    chk("sub imm", out_imm, 32'h0);

    send1(32'hFE736EE3, 32'h108);
    chk("bltu alu", 32'(out_ctrl.alu_func), 32'(ALU_FUNC_SLTU));
    chk("bltu rd_write", 32'(out_ctrl.rd_write), 32'd0);
    chk("bltu is_branch", 32'(out_is_branch), 32'd1);
    chk("bltu funct3", 32'(out_br_funct3), 32'd6);
    chk("bltu imm", out_imm, 32'hFFFFFFFC);

    send1(32'h00002063, 32'h10C);
    chk("badbr valid", 32'(out_valid), 32'd1);
    chk("badbr illegal", 32'(out_illegal), 32'd1);
    chk("badbr alu", 32'(out_ctrl.alu_func), 32'(ALU_FUNC_UNKNOWN));
    chk("badbr rd_write", 32'(out_ctrl.rd_write), 32'd0);

    // backpressure: 4 back-to-back, out_ready low for 3 cycles from beat 1
    bp_ins = '{32'h00108093, 32'h00210113, 32'h00318193, 32'h00420213};
    idx = 0; saw_low = 1'b0;
    for (int k = 0; k < 20 && idx < 4; k++) begin
      step(1'b1, bp_ins[idx], 32'h200 + 32'(idx * 4), !(k >= 1 && k <= 3), 1'b0, a);
      if (!in_ready) saw_low = 1'b1;
      if (a) idx++;
    end
    chk("bp all sent", 32'(idx), 32'd4);
    chk("bp in_ready fell", 32'(saw_low), 32'd1);
    repeat (4) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);

    // flush with main+skid full and a beat offered in the flush cycle
    step(1'b1, 32'h00500293, 32'h300, 1'b0, 1'b0, a);
    step(1'b1, 32'h00600313, 32'h304, 1'b0, 1'b0, a);
    step(1'b1, 32'h00700393, 32'h308, 1'b0, 1'b1, a);
    chk("pre-flush in_ready", 32'(in_ready), 32'd0);
    chk("pre-flush out_valid", 32'(out_valid), 32'd1);
`ifdef DECODE_PERF_CNT_EN
    perf_snap = perf_decoded;
`endif
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush in_ready", 32'(in_ready), 32'd1);
`ifdef DECODE_PERF_CNT_EN
    chk("flush perf", perf_decoded, perf_snap);
`endif

    // randomized stream with backpressure and occasional flush
    cur = rand_instr(); pcv = 32'h1000;
    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(0, 3) != 0, cur, pcv, $urandom_range(0, 2) != 0,
           $urandom_range(0, 49) == 0, a);
      if (a || flush) begin cur = rand_instr(); pcv = pcv + 32'd4; end
    end
    repeat (4) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);
    chk("drain sb empty", 32'(sb.size()), 32'd0);
`ifdef DECODE_PERF_CNT_EN
    chk("perf decoded", perf_decoded, 32'(tb_beats));
    chk("perf illegal", 32'(perf_illegal), 32'(tb_ill));
`endif

    // async reset mid-stream drops everything at once
    step(1'b1, 32'h00800413, 32'h400, 1'b0, 1'b0, a);
    step(1'b1, 32'h00900493, 32'h404, 1'b0, 1'b0, a);
    @(posedge clk); #3;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst in_ready", 32'(in_ready), 32'd1);
    chk("async rst pc", out_pc, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    send1(32'h00A00513, 32'h500);
    chk("post-rst pc", out_pc, 32'h500);
    repeat (2) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);
    chk("final sb empty", 32'(sb.size()), 32'd0);
`ifdef DECODE_PERF_CNT_EN
    chk("perf after rst", perf_decoded, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
